// File: rtl/alu_sched_if.sv
// alu_sched_if: requester, response and ALU-drive signals of the shared ALU
// scheduler. The scheduler connects through the slave modport. The master
// modport is the surrounding logic: the requesters plus the alu instance.
interface alu_sched_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req0_op1;
   logic [15:0] req0_op2;
   logic [4:0]  req0_opcode;
   logic        req0_cin;
   logic [15:0] req1_op1;
   logic [15:0] req1_op2;
   logic [4:0]  req1_opcode;
   logic        req1_cin;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [15:0] rsp_result;
   logic [5:0]  rsp_flags;     // {cf,nf,af,of,pf,zf}
   logic [15:0] alu_op1;
   logic [15:0] alu_op2;
   logic [4:0]  alu_opcode;
   logic        alu_cin;
   logic [15:0] alu_out;
   logic [5:0]  alu_flags;     // {cf,nf,af,of,pf,zf}
   logic        busy;

   modport slave (
      input  req_valid, req0_op1, req0_op2, req0_opcode, req0_cin,
             req1_op1, req1_op2, req1_opcode, req1_cin,
             rsp_ready, alu_out, alu_flags,
      output req_ready, rsp_valid, rsp_result, rsp_flags,
             alu_op1, alu_op2, alu_opcode, alu_cin, busy
   );

   modport master (
      output req_valid, req0_op1, req0_op2, req0_opcode, req0_cin,
             req1_op1, req1_op2, req1_opcode, req1_cin,
             rsp_ready, alu_out, alu_flags,
      input  req_ready, rsp_valid, rsp_result, rsp_flags,
             alu_op1, alu_op2, alu_opcode, alu_cin, busy
   );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler for two requesters sharing one 16-bit ALU.
// The block runs IDLE (grant and latch), then EXEC (drive the ALU and capture
// its result), then RESP (hold the response until the owner takes it).
// Optional feature: ALU_SCHED_CARRY_CHAIN_EN keeps a carry register for each
// requester. ADC and SBB then take their carry-in from that register, so each
// requester can chain multi-word arithmetic without disturbing the other.
module alu_sched (
   input  logic       clk,
   input  logic       rst_n,
   alu_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [15:0] op1;
      logic [15:0] op2;
      logic [4:0]  opcode;
      logic        cin;
   } op_t;

   state_t          state_q, state_d;
   op_t [1:0]       req_op;
   op_t             op_q;
   logic            gnt;       // requester chosen this cycle
   logic            gnt_q;     // owner of the in-flight operation
   logic            last_q;    // requester served most recently
   logic            accept;
   logic            rsp_done;
   logic [1:0]      req_ready_c;
   logic [15:0]     rsp_result_q;
   logic [5:0]      rsp_flags_q;
   logic            cin_eff;

   // Gather both requesters' fields so the grant can index them.
   always_comb begin
      req_op[0] = {bus.req0_op1, bus.req0_op2, bus.req0_opcode, bus.req0_cin};
      req_op[1] = {bus.req1_op1, bus.req1_op2, bus.req1_opcode, bus.req1_cin};
   end

   // Round-robin: a lone requester always wins; on a tie, the one not served last wins.
   always_comb begin
      gnt = ~last_q;
      case (bus.req_valid)
         2'b01:   gnt = 1'b0;
         2'b10:   gnt = 1'b1;
         default: gnt = ~last_q;
      endcase
   end

   // Next-state logic, plus the accept and release strobes.
   always_comb begin
      state_d     = state_q;
      req_ready_c = 2'b00;
      accept      = 1'b0;
      rsp_done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               req_ready_c[gnt] = 1'b1;
               accept           = 1'b1;
               state_d          = EXEC;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            if (bus.rsp_ready[gnt_q]) begin
               rsp_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Keep req_ready low while reset is asserted, even if a requester is presenting.
   always_comb bus.req_ready = rst_n ? req_ready_c : 2'b00;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Latch the granted operation and its owner at the accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= '0;
         gnt_q <= 1'b0;
      end else if (accept) begin
         op_q  <= req_op[gnt];
         gnt_q <= gnt;
      end
   end

   // Record the served requester when its response is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        last_q <= 1'b1;
      else if (rsp_done) last_q <= gnt_q;
   end

   // Capture the ALU result at the end of EXEC. It stays stable through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else if (state_q == EXEC) begin
         rsp_result_q <= bus.alu_out;
         rsp_flags_q  <= bus.alu_flags;
      end
   end

`ifdef ALU_SCHED_CARRY_CHAIN_EN
   localparam logic [4:0] OPC_ADC = 5'b00101;
   localparam logic [4:0] OPC_SBB = 5'b00111;

   logic [1:0] carry_q;

   // The ADD/ADC/SUB/SBB group (00100-00111) updates the owner's carry from cf.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         carry_q <= 2'b00;
      else if (state_q == EXEC && op_q.opcode[4:2] == 3'b001)
         carry_q[gnt_q] <= bus.alu_flags[5];
   end

   // ADC and SBB chain through the stored carry. Other opcodes use the requester's cin.
   always_comb begin
      cin_eff = op_q.cin;
      if (op_q.opcode == OPC_ADC || op_q.opcode == OPC_SBB)
         cin_eff = carry_q[gnt_q];
   end
`else
   // Without carry chaining, the carry-in is always the requester's own cin.
   always_comb cin_eff = op_q.cin;
`endif

   // Drive the ALU only in EXEC. Outside EXEC, hold its inputs at zero.
   always_comb begin
      bus.alu_op1    = '0;
      bus.alu_op2    = '0;
      bus.alu_opcode = 5'b00000;
      bus.alu_cin    = 1'b0;
      if (state_q == EXEC) begin
         bus.alu_op1    = op_q.op1;
         bus.alu_op2    = op_q.op2;
         bus.alu_opcode = op_q.opcode;
         bus.alu_cin    = cin_eff;
      end
   end

   // Present the response to its owner only, and only while in RESP.
   always_comb begin
      bus.rsp_valid = 2'b00;
      if (state_q == RESP) bus.rsp_valid[gnt_q] = 1'b1;
      bus.rsp_result = rsp_result_q;
      bus.rsp_flags  = rsp_flags_q;
      bus.busy       = (state_q != IDLE);
   end

`ifndef SYNTHESIS
   // Handshake sanity: single grant, single response owner, no accept while busy.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert ($onehot0(bus.req_ready));
         assert ($onehot0(bus.rsp_valid));
         assert (!(bus.busy && (bus.req_ready != 2'b00)));
      end
   end
`endif

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler and sequencer for the shared 16-bit ALU. It arbitrates between two operation requesters using valid/ready handshakes, then drives the combinational ALU from registered operands for one execute cycle. It captures the result and flags into a response register and returns them to the requester that issued the operation. It sits between the instruction/issue logic and the `alu` instance, and is the only block that drives the ALU inputs.

## Interface
- No parameters. Data width is fixed at 16, opcode width at 5, and flag width at 6.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req_valid  in  2`: bit i means requester i presents an operation.
- `req_ready  out  2`: bit i means the scheduler accepts requester i's operation this cycle.
- `req0_op1, req0_op2  in  16 each`: requester 0 operands.
- `req0_opcode  in  5`: requester 0 ALU opcode.
- `req0_cin  in  1`: requester 0 carry-in.
- `req1_op1, req1_op2, req1_opcode, req1_cin  in  16/16/5/1`: requester 1 equivalents.
- `rsp_valid  out  2`: bit i means the response for requester i is valid.
- `rsp_ready  in  2`: bit i means requester i consumes the response.
- `rsp_result  out  16`: captured ALU `out`.
- `rsp_flags  out  6`: captured flags, ordered {cf,nf,af,of,pf,zf}.
- `alu_op1, alu_op2  out  16`: to the ALU.
- `alu_opcode  out  5`: to the ALU.
- `alu_cin  out  1`: to the ALU.
- `alu_out  in  16`: from the ALU.
- `alu_flags  in  6`: from the ALU, ordered {cf,nf,af,of,pf,zf}.
- `busy  out  1`: high in every state except IDLE.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req_valid` bit is set, grant one requester by round-robin.
  - Round-robin rule: prefer the requester not served last. `last` resets to 1, so requester 0 wins first.
  - Assert `req_ready[g]` combinationally for the granted requester only.
  - Latch op1, op2, opcode, cin and g.
  - Go to EXEC.
- **EXEC:**
  - Drive `alu_*` from the latched registers.
  - At the end of the cycle, capture `alu_out` into `rsp_result` and `alu_flags` into `rsp_flags`.
  - Go to RESP.
- **RESP:**
  - Hold `rsp_valid[g]`=1 and the response registers stable.
  - When `rsp_ready[g]`=1: set `last`←g, go to IDLE.
  - `rsp_ready` on the other bit is ignored.
- **ALU drive outside EXEC:** `alu_op1`/`alu_op2`=0, `alu_opcode`=5'b00000, `alu_cin`=0.
- **Acceptance:**
  - `req_ready` is 0 in EXEC and RESP; requests are never accepted while busy.
  - At most one `req_ready` bit is ever high.
- **Response identity:** `rsp_valid` is one-hot or zero. Response data is valid only while the matching `rsp_valid` bit is high.
- **Opcode handling:**
  - Opcodes pass through unmodified; the scheduler does not decode them except for carry handling (see Configuration).
  - Unused opcodes execute normally and return whatever the ALU produces.

## Timing
- **Reset values:**
  - State IDLE, `last`=1, carry registers 0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0.
  - `alu_*` outputs 0, `busy`=0.
- **Latency:** request accepted in cycle N (IDLE, `req_valid`&`req_ready`), EXEC in N+1, `rsp_valid` high from N+2.
- **Throughput:** with `rsp_ready` held high, the next accept is at N+3, so one operation per 3 cycles.
- **Backpressure:** RESP holds indefinitely while `rsp_ready[g]`=0; no new operation is accepted meanwhile.
- **Simultaneous requests:** both valid in IDLE gives strict alternation across back-to-back operations. A single valid requester is always granted regardless of `last`.
- **Request withdrawal:** dropping `req_valid` in IDLE is legal; nothing is latched unless `req_ready` was high in that cycle.
- **Reset mid-operation:** asserting `rst_n` low in any state immediately forces all reset values. The in-flight operation is discarded and no response is issued.

## Configuration
- Macro: `ALU_SCHED_CARRY_CHAIN_EN`.
- **Defined:**
  - One carry register per requester.
  - On opcodes 5'b00101 (ADC) and 5'b00111 (SBB), `alu_cin` = that requester's carry register. `reqN_cin` is ignored.
  - On other opcodes, `alu_cin` = the latched `reqN_cin`.
  - At the end of EXEC for opcodes 5'b00100–5'b00111, the requester's carry register ← `alu_flags[5]` (cf). Other opcodes leave it unchanged.
  - Multi-word arithmetic chains per requester without interference.
- **Undefined:** no carry registers; `alu_cin` is always the latched `reqN_cin`.

## Test plan
- Reset, then req0 ADD (00100) op1=0xFFFF, op2=0x0001 -> `req_ready`=2'b01 in the same cycle; `alu_opcode`=00100 one cycle later; `rsp_valid`=2'b01 two cycles after accept; `rsp_result`=0x0000, `rsp_flags[5]`=1.
- `ALU_SCHED_CARRY_CHAIN_EN` defined: after the previous case, req0 ADC (00101) with 0x0000+0x0000, `req0_cin`=0 -> `alu_cin`=1, `rsp_result`=0x0001. A req1 ADC with identical operands -> `alu_cin`=0, result 0x0000. Macro undefined: the req0 ADC gives `alu_cin`=0, result 0x0000.
- Both `req_valid` held high for 4 operations with `rsp_ready`=2'b11 -> grants in order 0,1,0,1; accepts exactly 3 cycles apart.
- Response held with `rsp_ready`=0 for 5 cycles -> `rsp_valid`, `rsp_result` and `rsp_flags` stable; `req_ready`=0 throughout; `busy`=1.
- `rst_n` pulsed low during EXEC -> all outputs 0 immediately; no `rsp_valid` follows; the next request is granted to req0.
- `alu_*` outputs checked to be 0 in every non-EXEC cycle across all scenarios.
